pipeline_hazard_ctrl: RTL and testbench



---
 rtl/pipeline_hazard_ctrl_if.sv | 57 +++++
 rtl/pipeline_hazard_ctrl.sv | 167 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle: register ids, write enables,
// branch/memory handshake going in; stall/flush/forward controls,
// performance counters and the sticky memory error coming out.
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  // Operand / destination register ids per stage
  logic [4:0]       Rs1D;
  logic [4:0]       Rs2D;
  logic [4:0]       Rs1E;
  logic [4:0]       Rs2E;
  logic [4:0]       RdE;
  logic [4:0]       RdM;
  logic [4:0]       RdW;

  // Pipeline status and data-memory handshake
  logic             RegWriteM;
  logic             RegWriteW;
  logic             ResultSrcE0;
  logic             PCSrcE;
  logic             MemReqM;
  logic             MemReadyM;

  // Controls returned to the pipeline
  logic             StallF;
  logic             StallD;
  logic             StallE;
  logic             StallM;
  logic             FlushD;
  logic             FlushE;
  logic             FlushW;
  logic [1:0]       ForwardAE;
  logic [1:0]       ForwardBE;

  // Observability
  logic [CNT_W-1:0] LoadStallCnt;
  logic [CNT_W-1:0] MemWaitCnt;
  logic             MemErr;

  // Pipeline side: supplies status, consumes controls
  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MemReqM, MemReadyM,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
    input  ForwardAE, ForwardBE,
    input  LoadStallCnt, MemWaitCnt, MemErr
  );

  // Controller side
  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MemReqM, MemReadyM,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
    output ForwardAE, ForwardBE,
    output LoadStallCnt, MemWaitCnt, MemErr
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32 pipeline.
// Combinational forwarding, load-use and branch handling, plus a small
// FSM that freezes the whole pipeline while M-stage data memory is busy
// and forces a release (flagging MemErr) after MEM_TIMEOUT wait cycles.
module pipeline_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input logic                clk,
  input logic                rst_n,
  pipeline_hazard_ctrl_if.slave bus
);

  localparam int unsigned         WAIT_W  = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0]   TIMEOUT = WAIT_W'(MEM_TIMEOUT);

  typedef enum logic {
    RUN,
    MEM_WAIT
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_next;
  logic              mem_err;
  logic              err_next;
  logic [CNT_W-1:0]  load_stall_cnt;
  logic [CNT_W-1:0]  mem_wait_cnt;

  logic              mem_pending;
  logic              mem_stall;
  logic              lw_stall;
  logic              lw_win;

  // Operand source: M result beats W result; x0 is never forwarded
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic       reg_write_m,
    input logic [4:0] rd_m,
    input logic       reg_write_w,
    input logic [4:0] rd_w
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      sel = 2'b10;
    end else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  // Hazard conditions and which of them wins this cycle
  always_comb begin
    mem_pending = bus.MemReqM && !bus.MemReadyM;
    mem_stall   = mem_pending && (wait_cnt < TIMEOUT);
    lw_stall    = bus.ResultSrcE0 && (bus.RdE != 5'd0) &&
                  ((bus.Rs1D == bus.RdE) || (bus.Rs2D == bus.RdE));
    // A taken branch discards D, so a coincident load-use is not a stall
    lw_win      = lw_stall && !mem_stall && !bus.PCSrcE;
  end

  // Stall / flush / forward outputs, forced inactive while in reset
  always_comb begin
    bus.StallF    = 1'b0;
    bus.StallD    = 1'b0;
    bus.StallE    = 1'b0;
    bus.StallM    = 1'b0;
    bus.FlushD    = 1'b0;
    bus.FlushE    = 1'b0;
    bus.FlushW    = 1'b0;
    bus.ForwardAE = 2'b00;
    bus.ForwardBE = 2'b00;
    if (rst_n) begin
      bus.ForwardAE = fwd_sel(bus.Rs1E, bus.RegWriteM, bus.RdM,
                              bus.RegWriteW, bus.RdW);
      bus.ForwardBE = fwd_sel(bus.Rs2E, bus.RegWriteM, bus.RdM,
                              bus.RegWriteW, bus.RdW);
      if (mem_stall) begin
        // Whole pipe frozen; W gets a bubble so nothing retires twice
        bus.StallF = 1'b1;
        bus.StallD = 1'b1;
        bus.StallE = 1'b1;
        bus.StallM = 1'b1;
        bus.FlushW = 1'b1;
      end else if (bus.PCSrcE) begin
        bus.FlushD = 1'b1;
        bus.FlushE = 1'b1;
      end else if (lw_stall) begin
        bus.StallF = 1'b1;
        bus.StallD = 1'b1;
        bus.FlushE = 1'b1;
      end
    end
  end

  // Memory-wait FSM next state, wait counter and timeout detection
  always_comb begin
    state_next = state;
    wait_next  = wait_cnt;
    err_next   = mem_err;
    unique case (state)
      RUN: begin
        if (mem_stall) begin
          state_next = MEM_WAIT;
          wait_next  = WAIT_W'(1);
        end else begin
          wait_next  = '0;
        end
      end
      MEM_WAIT: begin
        if (!mem_pending) begin
          state_next = RUN;
          wait_next  = '0;
        end else if (wait_cnt < TIMEOUT) begin
          wait_next  = wait_cnt + 1'b1;
        end else begin
          // Timed out: mem_stall is already low, so the pipe moves on now
          state_next = RUN;
          wait_next  = '0;
          err_next   = 1'b1;
        end
      end
      default: begin
        state_next = RUN;
        wait_next  = '0;
      end
    endcase
  end

  // FSM state, wait counter and sticky error register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_next;
      mem_err  <= err_next;
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_stall_cnt <= '0;
      mem_wait_cnt   <= '0;
    end else begin
      if (lw_win && (load_stall_cnt != '1)) begin
        load_stall_cnt <= load_stall_cnt + 1'b1;
      end
      if (mem_stall && (mem_wait_cnt != '1)) begin
        mem_wait_cnt <= mem_wait_cnt + 1'b1;
      end
    end
  end

  // Observability outputs
  always_comb begin
    bus.LoadStallCnt = load_stall_cnt;
    bus.MemWaitCnt   = mem_wait_cnt;
    bus.MemErr       = mem_err;
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl: two instances sharing stimulus
// (16-bit and 2-bit counters, both with a 4-cycle memory timeout),
// vector table, directed corner sequences and randomized traffic
// against a behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int T = 4;

  logic       clk;
  logic       rst_n;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MemReqM, MemReadyM;

  pipeline_hazard_ctrl_if #(.CNT_W(16)) bus_a ();
  pipeline_hazard_ctrl_if #(.CNT_W(2))  bus_b ();

  assign bus_a.Rs1D = Rs1D;               assign bus_b.Rs1D = Rs1D;
  assign bus_a.Rs2D = Rs2D;               assign bus_b.Rs2D = Rs2D;
  assign bus_a.Rs1E = Rs1E;               assign bus_b.Rs1E = Rs1E;
  assign bus_a.Rs2E = Rs2E;               assign bus_b.Rs2E = Rs2E;
  assign bus_a.RdE = RdE;                 assign bus_b.RdE = RdE;
  assign bus_a.RdM = RdM;                 assign bus_b.RdM = RdM;
  assign bus_a.RdW = RdW;                 assign bus_b.RdW = RdW;
  assign bus_a.RegWriteM = RegWriteM;     assign bus_b.RegWriteM = RegWriteM;
  assign bus_a.RegWriteW = RegWriteW;     assign bus_b.RegWriteW = RegWriteW;
  assign bus_a.ResultSrcE0 = ResultSrcE0; assign bus_b.ResultSrcE0 = ResultSrcE0;
  assign bus_a.PCSrcE = PCSrcE;           assign bus_b.PCSrcE = PCSrcE;
  assign bus_a.MemReqM = MemReqM;         assign bus_b.MemReqM = MemReqM;
  assign bus_a.MemReadyM = MemReadyM;     assign bus_b.MemReadyM = MemReadyM;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
  );
  pipeline_hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b)
  );

  // {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
  logic [6:0] ctl_a, ctl_b;
  assign ctl_a = {bus_a.StallF, bus_a.StallD, bus_a.StallE, bus_a.StallM,
                  bus_a.FlushD, bus_a.FlushE, bus_a.FlushW};
  assign ctl_b = {bus_b.StallF, bus_b.StallD, bus_b.StallE, bus_b.StallM,
                  bus_b.FlushD, bus_b.FlushE, bus_b.FlushW};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: length of the current stalled run, raw event counts
  int         m_wait;
  int         m_lw;
  int         m_mw;
  bit         m_err;
  logic [6:0] e_ctl;
  logic [1:0] e_fa, e_fb;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int raw, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (raw > mx) ? mx : raw;
  endfunction

  function automatic logic [1:0] m_fwd(input logic [4:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_reset();
    m_wait = 0; m_lw = 0; m_mw = 0; m_err = 1'b0;
  endtask

  function automatic bit m_memstall();
    return rst_n && MemReqM && !MemReadyM && (m_wait < T);
  endfunction

  function automatic bit m_lwstall();
    return ResultSrcE0 && RdE != 0 && (Rs1D == RdE || Rs2D == RdE);
  endfunction

  // Let inputs settle, compute expected combinational outputs, compare
  task automatic settle_check();
    #1;
    e_ctl = 7'b0; e_fa = 2'b00; e_fb = 2'b00;
    if (rst_n) begin
      e_fa = m_fwd(Rs1E);
      e_fb = m_fwd(Rs2E);
      if (m_memstall())    e_ctl = 7'b1111001;
      else if (PCSrcE)     e_ctl = 7'b0000110;
      else if (m_lwstall()) e_ctl = 7'b1100010;
    end
    chk("ctl_a", ctl_a, e_ctl);
    chk("ctl_b", ctl_b, e_ctl);
    chk("fwdA", bus_a.ForwardAE, e_fa);
    chk("fwdB", bus_a.ForwardBE, e_fb);
  endtask

  // Clock edge, advance model, compare registered outputs
  task automatic clock_step();
    bit ms;
    ms = m_memstall();
    @(posedge clk);
    if (rst_n) begin
      if (ms) begin
        m_wait++;
        m_mw++;
      end else begin
        if (MemReqM && !MemReadyM) m_err = 1'b1;
        m_wait = 0;
      end
      if (!ms && !PCSrcE && m_lwstall()) m_lw++;
    end
    #1;
    chk("lwcnt_a", bus_a.LoadStallCnt, sat(m_lw, 16));
    chk("mwcnt_a", bus_a.MemWaitCnt, sat(m_mw, 16));
    chk("err_a", bus_a.MemErr, m_err);
    chk("lwcnt_b", bus_b.LoadStallCnt, sat(m_lw, 2));
    chk("mwcnt_b", bus_b.MemWaitCnt, sat(m_mw, 2));
    chk("err_b", bus_b.MemErr, m_err);
  endtask

  task automatic clear_inputs();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    RegWriteM = 0; RegWriteW = 0; ResultSrcE0 = 0; PCSrcE = 0;
    MemReqM = 0; MemReadyM = 0;
  endtask

  typedef struct {
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic       rwm, rww, ld, pc;
    logic [1:0] fa, fb;
    logic [6:0] ctl;
  } vec_t;

  vec_t vecs[10];

  initial begin
    //           rs1d rs2d rs1e rs2e rde rdm rdw rwm rww ld pc  fa     fb     ctl
    vecs[0] = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 1, 1, 0, 0, 2'b10, 2'b00, 7'b0000000};
    vecs[1] = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 0, 1, 0, 0, 2'b01, 2'b00, 7'b0000000};
    vecs[2] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1, 1, 0, 0, 2'b00, 2'b00, 7'b0000000};
    vecs[3] = '{5'd0, 5'd0, 5'd4, 5'd3, 5'd0, 5'd4, 5'd3, 1, 1, 0, 0, 2'b10, 2'b01, 7'b0000000};
    vecs[4] = '{5'd0, 5'd0, 5'd1, 5'd8, 5'd0, 5'd8, 5'd8, 0, 0, 0, 0, 2'b00, 2'b00, 7'b0000000};
    vecs[5] = '{5'd9, 5'd1, 5'd0, 5'd0, 5'd9, 5'd0, 5'd0, 0, 0, 1, 0, 2'b00, 2'b00, 7'b1100010};
    vecs[6] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 2'b00, 2'b00, 7'b0000000};
    vecs[7] = '{5'd2, 5'd6, 5'd0, 5'd0, 5'd6, 5'd0, 5'd0, 0, 0, 1, 1, 2'b00, 2'b00, 7'b0000110};
    vecs[8] = '{5'd2, 5'd2, 5'd0, 5'd0, 5'd6, 5'd0, 5'd0, 0, 0, 1, 0, 2'b00, 2'b00, 7'b0000000};
    vecs[9] = '{5'd0, 5'd0, 5'd7, 5'd7, 5'd0, 5'd0, 5'd7, 0, 1, 0, 1, 2'b01, 2'b01, 7'b0000110};

    // Reset state, with inputs that would otherwise forward
    clear_inputs();
    rst_n = 1'b0;
    model_reset();
    RegWriteM = 1; RdM = 5; Rs1E = 5;
    #1;
    chk("rst_ctl", ctl_a, 0);
    chk("rst_fwdA", bus_a.ForwardAE, 0);
    chk("rst_lwcnt", bus_a.LoadStallCnt, 0);
    chk("rst_mwcnt", bus_a.MemWaitCnt, 0);
    chk("rst_err", bus_a.MemErr, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clear_inputs();

    // Load-use: one stall cycle, counter 0 -> 1
    ResultSrcE0 = 1; RdE = 7; Rs2D = 7;
    settle_check();
    chk("lu_ctl", ctl_a, 7'b1100010);
    clock_step();
    chk("lu_cnt", bus_a.LoadStallCnt, 1);

    // Branch beats load-use; counter unchanged
    PCSrcE = 1;
    settle_check();
    chk("br_ctl", ctl_a, 7'b0000110);
    clock_step();
    chk("br_cnt", bus_a.LoadStallCnt, 1);
    clear_inputs();

    // Memory wait of 3 cycles with a branch waiting in E
    MemReqM = 1; MemReadyM = 0; PCSrcE = 1;
    for (int i = 0; i < 3; i++) begin
      settle_check();
      chk("mw_ctl", ctl_a, 7'b1111001);
      clock_step();
    end
    MemReadyM = 1;
    settle_check();
    chk("mw_rel_ctl", ctl_a, 7'b0000110);
    clock_step();
    chk("mw_cnt", bus_a.MemWaitCnt, 3);
    chk("mw_err", bus_a.MemErr, 0);
    clear_inputs();
    settle_check();
    chk("mw_run", ctl_a, 0);
    clock_step();

    // Timeout: 4 stalled cycles, 5th released, MemErr set
    MemReqM = 1; MemReadyM = 0;
    for (int i = 0; i < T; i++) begin
      settle_check();
      chk("to_stall", bus_a.StallF, 1);
      clock_step();
    end
    settle_check();
    chk("to_rel", ctl_a, 0);
    clock_step();
    chk("to_err", bus_a.MemErr, 1);
    chk("to_cnt", bus_a.MemWaitCnt, 7);
    clear_inputs();

    // Vector table
    foreach (vecs[i]) begin
      Rs1D = vecs[i].rs1d; Rs2D = vecs[i].rs2d; Rs1E = vecs[i].rs1e;
      Rs2E = vecs[i].rs2e; RdE = vecs[i].rde;   RdM = vecs[i].rdm;
      RdW = vecs[i].rdw;   RegWriteM = vecs[i].rwm; RegWriteW = vecs[i].rww;
      ResultSrcE0 = vecs[i].ld; PCSrcE = vecs[i].pc;
      settle_check();
      chk("vec_fa", bus_a.ForwardAE, vecs[i].fa);
      chk("vec_fb", bus_a.ForwardBE, vecs[i].fb);
      chk("vec_ctl", ctl_a, vecs[i].ctl);
      clock_step();
    end
    chk("vec_err_sticky", bus_a.MemErr, 1);
    clear_inputs();

    // Reset during the second wait cycle
    RegWriteM = 1; RdM = 5; Rs1E = 5;
    MemReqM = 1; MemReadyM = 0;
    settle_check();
    clock_step();
    settle_check();
    chk("rmw_stall", bus_a.StallM, 1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rmw_ctl", ctl_a, 0);
    chk("rmw_fwdA", bus_a.ForwardAE, 0);
    chk("rmw_mwcnt", bus_a.MemWaitCnt, 0);
    chk("rmw_lwcnt", bus_a.LoadStallCnt, 0);
    chk("rmw_err", bus_a.MemErr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    MemReqM = 0;
    settle_check();
    chk("rmw_run", ctl_a, 0);
    clock_step();
    chk("rmw_cnt2", bus_a.MemWaitCnt, 0);
    chk("rmw_err2", bus_a.MemErr, 0);
    clear_inputs();

    // Saturation on the 2-bit counter instance
    ResultSrcE0 = 1; RdE = 7; Rs2D = 7;
    repeat (5) begin
      settle_check();
      clock_step();
    end
    chk("sat_b", bus_b.LoadStallCnt, 3);
    chk("sat_a", bus_a.LoadStallCnt, 5);
    clear_inputs();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
      Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
      RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
      RdW  = 5'($urandom_range(0, 3));
      RegWriteM   = ($urandom_range(0, 99) < 60);
      RegWriteW   = ($urandom_range(0, 99) < 60);
      ResultSrcE0 = ($urandom_range(0, 99) < 30);
      PCSrcE      = ($urandom_range(0, 99) < 15);
      MemReqM     = ($urandom_range(0, 99) < 50);
      MemReadyM   = ($urandom_range(0, 99) < 35);
      settle_check();
      clock_step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
